exhaustive_stim_gen: RTL

- Synthesizable stimulus/response sequencer that sits directly upstream of a small combinational lab block (4 inputs, 2 outputs) and drives it.
- Walks every input combination 0..2^N_IN-1 in ascending binary order and holds each one for HOLD_CYCLES clocks.
- Samples the block's outputs at the end of each hold window and packs them into a response log.
- Replaces hand-written exhaustive stimulus with a reusable hardware stage for on-board and simulation checking.

---
 rtl/exhaustive_stim_gen_if.sv | 27 ++
 rtl/exhaustive_stim_gen.sv | 109 ++++++++++
 2 files changed

// File: rtl/exhaustive_stim_gen_if.sv
// Stimulus/response bus between the exhaustive sequencer and its consumer.
interface exhaustive_stim_gen_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2
);
  localparam int unsigned LOG_W = (1 << N_IN) * N_OUT;

  logic              start;
  logic [N_OUT-1:0]  resp;
  logic [N_IN-1:0]   stim;
  logic              busy;
  logic              done;
  logic [N_IN-1:0]   vec_idx;
  logic              sample_valid;
  logic [N_IN-1:0]   sample_idx;
  logic [LOG_W-1:0]  resp_log;

  modport master (
    input  start, resp,
    output stim, busy, done, vec_idx, sample_valid, sample_idx, resp_log
  );

  modport slave (
    output start, resp,
    input  stim, busy, done, vec_idx, sample_valid, sample_idx, resp_log
  );
endinterface

// File: rtl/exhaustive_stim_gen.sv
// Walks every input vector in ascending order, holds each for HOLD_CYCLES
// clocks and captures the block-under-test response into a packed log.
module exhaustive_stim_gen #(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned N_OUT       = 2,
  parameter int unsigned HOLD_CYCLES = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  exhaustive_stim_gen_if.master bus
);
  localparam int unsigned NUM_VEC = 1 << N_IN;
  localparam int unsigned LOG_W   = NUM_VEC * N_OUT;
  localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [N_IN-1:0]   LAST_VEC  = N_IN'(NUM_VEC - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e            state_q,  state_d;
  logic [N_IN-1:0]   vec_q,    vec_d;
  logic [HOLD_W-1:0] hold_q,   hold_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic              sv_q,     sv_d;
  logic [N_IN-1:0]   sidx_q,   sidx_d;
  logic [LOG_W-1:0]  log_q,    log_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sv_d    = 1'b0;
    sidx_d  = sidx_q;
    log_d   = log_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_APPLY;
          vec_d   = '0;
          hold_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          log_d   = '0;
        end
      end

      S_APPLY: begin
        if (hold_q == LAST_HOLD) begin
          hold_d = '0;
          log_d[int'(vec_q) * N_OUT +: N_OUT] = bus.resp;
          sv_d   = 1'b1;
          sidx_d = vec_q;
          // Last vector stays applied after completion; no wrap to 0
          if (vec_q == LAST_VEC) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sv_q    <= 1'b0;
      sidx_q  <= '0;
      log_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sv_q    <= sv_d;
      sidx_q  <= sidx_d;
      log_q   <= log_d;
    end
  end

  assign bus.stim         = vec_q;
  assign bus.vec_idx      = vec_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.sample_valid = sv_q;
  assign bus.sample_idx   = sidx_q;
  assign bus.resp_log     = log_q;

endmodule
